imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Single-cycle-issue arbiter and read sequencer for the 128-word instruction memory. It shares the memory's single port between the fetch stage, which issues read-only requests, and the program loader, which issues write-only requests. It registers read responses into a fixed two-cycle pipeline, supports a branch flush that discards in-flight reads, and flags out-of-range fetch addresses. It sits between the PC/fetch logic and the instruction memory array.

## Interface
- `DEPTH`, 128: memory depth in words; addresses are word indices.
- `AW`, 7: memory address width, log2(`DEPTH`).
- `STARVE_MAX`, 4: consecutive loader wins tolerated while fetch waits (used only with the fairness feature).

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch read request, held until granted.
- `if_addr` in 32: fetch word index.
- `if_flush` in 1: branch redirect; kills in-flight and same-cycle fetches.
- `if_gnt` out 1: fetch request accepted this cycle (combinational).
- `if_valid` out 1: registered response valid.
- `if_rdata` out 32: registered instruction word.
- `if_err` out 1: registered; response was an out-of-range address.
- `ld_req` in 1: loader write request.
- `ld_addr` in 32: loader word index.
- `ld_wdata` in 32: loader write data.
- `ld_gnt` out 1: write accepted this cycle (combinational).
- `mem_addr` out AW: memory address (combinational from the grant).
- `mem_we` out 1: memory write enable.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: synchronous-read data, valid the cycle after the address is presented.

## Operation
- Grant rules:
  - At most one grant per cycle.
  - `ld_gnt` and `if_gnt` are never high together.
- Priority: the loader beats fetch, except when the fairness feature forces a fetch win.
- Fetch is never granted in a cycle with `if_flush`=1 or `reset`=1.
- Out-of-range loader address (`ld_addr`>=`DEPTH`):
  - `ld_gnt`=1 (the request is consumed).
  - `mem_we`=0, so the write is dropped.
- Memory port driving:
  - Loader grant: `mem_addr`=`ld_addr[AW-1:0]`, `mem_we`=1, `mem_wdata`=`ld_wdata`.
  - Fetch grant: `mem_addr`=`if_addr[AW-1:0]`, `mem_we`=0.
  - Idle: `mem_addr`=0, `mem_we`=0, `mem_wdata`=0.
- Response pipeline:
  - Stage 1 register: {valid, err}. `err` = `if_addr`>=`DEPTH`. For an out-of-range fetch the memory is still read (harmlessly), but the data is masked.
  - Stage 2 register: {`if_valid`, `if_err`, `if_rdata`}. `if_rdata` = `mem_rdata` when not err, else 0.
- Flush:
  - `if_flush`=1 clears the stage 1 and stage 2 valid bits at that clock edge.
  - No response from a fetch granted before or during the flush cycle ever appears.
- Fetch responses return in grant order. Loader writes produce no response.

## Timing
- Reset values: `if_valid`=0, `if_err`=0, `if_rdata`=0, both pipeline valids=0, starve counter=0. All combinational outputs are 0 while `reset`=1.
- Fetch latency:
  - Grant in cycle N.
  - `if_valid`=1 in cycle N+2 (single-cycle pulse per grant).
  - Back-to-back grants give back-to-back responses.
- Write latency: a write granted in cycle N lands at the N/N+1 clock edge. A fetch to the same address granted in N+1 returns the new data.
- Simultaneous `ld_req` and `if_req`: the loader wins (subject to fairness). Fetch sees `if_gnt`=0 and holds its request.
- Reset mid-operation: pipeline contents are discarded. No `if_valid` appears for any pre-reset grant.
- `if_flush` together with `reset`: behaviour is identical to reset alone.

## Configuration
- `IMEM_ARB_FAIR_EN` defined:
  - A starve counter increments each cycle the loader is granted while `if_req`=1 and `if_flush`=0. It saturates at `STARVE_MAX`.
  - When the counter equals `STARVE_MAX` and both requests are present, fetch is granted and the counter clears.
  - The counter also clears on any fetch grant or whenever `if_req`=0.
- `IMEM_ARB_FAIR_EN` undefined:
  - Strict loader priority; no counter logic.
  - Fetch can starve indefinitely under continuous `ld_req`.

## Test plan
- Fetch-only: `if_addr`=0,1,2 on consecutive cycles with the memory preloaded 0x014A5020, 0x00221822, 0x00632020 → `if_valid` in cycles N+2..N+4 with those words in order.
- Write-then-read: loader writes 0xDEADBEEF to address 5 in cycle N, fetch of address 5 in N+1 → `if_rdata`=0xDEADBEEF in N+3.
- Contention, with `IMEM_ARB_FAIR_EN`, `STARVE_MAX`=4: `ld_req` and `if_req` both held high → 4 loader grants, 1 fetch grant, repeating. Without the macro → zero fetch grants.
- Flush: fetches granted in N and N+1, `if_flush` in N+1 → no `if_valid` in N+2 or N+3. A new fetch in N+2 returns in N+4.
- Range: `if_addr`=128 → `if_valid`=1, `if_err`=1, `if_rdata`=0. `ld_addr`=200 → `ld_gnt`=1, `mem_we`=0.
- Reset mid-stream: `reset` asserted one cycle after a fetch grant → no `if_valid` afterward, all outputs 0 during reset.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Shares the single port of the 128-word instruction memory between the
//   fetch stage (reads) and the program loader (writes). A granted fetch
//   returns its word through a fixed two-stage response pipeline (grant in
//   N, if_valid in N+2). if_flush kills in-flight and same-cycle fetches.
//   Out-of-range fetches return if_err=1 with zeroed data. Out-of-range
//   loader writes are consumed but dropped.
//
//   Optional feature: define IMEM_ARB_FAIR_EN to bound fetch starvation.
//   Fetch then wins after STARVE_MAX consecutive loader wins.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   if_req/if_addr      fetch request and word index
//   if_flush            branch redirect
//   if_gnt              fetch accepted this cycle (combinational)
//   if_valid/if_rdata/if_err  registered fetch response
//   ld_req/ld_addr/ld_wdata   loader write request
//   ld_gnt              write accepted this cycle (combinational)
//   mem_addr/mem_we/mem_wdata memory port drive (combinational)
//   mem_rdata           synchronous-read data, one cycle after the address
module imem_arbiter #(
  parameter int DEPTH      = 128,
  parameter int AW         = 7,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  input  logic          ld_req,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_gnt,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  logic fetch_ok;
  logic force_fetch;
  logic if_oor;
  logic ld_oor;
  logic s1_valid;
  logic s1_err;

  // Fetch can never be granted during reset or a flush cycle.
  assign fetch_ok = if_req && !if_flush && !reset;
  assign if_oor   = (if_addr >= 32'(DEPTH));
  assign ld_oor   = (ld_addr >= 32'(DEPTH));

`ifdef IMEM_ARB_FAIR_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;

  assign force_fetch = fetch_ok && (starve_cnt == SW'(STARVE_MAX));

  // Counts loader wins that made a live fetch wait. A flush cycle neither
  // advances nor clears it, because fetch could not have been granted anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (ld_gnt && !if_flush && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  logic unused_cfg;

  assign force_fetch = 1'b0;
  assign unused_cfg  = (STARVE_MAX > 0);
`endif

  assign ld_gnt = !reset && ld_req && !force_fetch;
  assign if_gnt = fetch_ok && (!ld_req || force_fetch);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_addr  = ld_addr[AW-1:0];
      mem_we    = !ld_oor;
      mem_wdata = ld_wdata;
    end else if (if_gnt) begin
      mem_addr = if_addr[AW-1:0];
    end
  end

  // Stage 1 tracks the read in flight inside the memory; stage 2 captures
  // its data. An out-of-range read still happens but its data is masked.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      if_valid <= 1'b0;
      if_err   <= 1'b0;
      if_rdata <= '0;
    end else begin
      s1_valid <= if_gnt;
      s1_err   <= if_gnt && if_oor;
      if_valid <= s1_valid && !if_flush;
      if_err   <= s1_valid && s1_err && !if_flush;
      if_rdata <= (s1_valid && !s1_err && !if_flush) ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int SMAX  = 4;

  logic          clk = 1'b0;
  logic          reset, if_req, if_flush, ld_req;
  logic [31:0]   if_addr, ld_addr, ld_wdata;
  logic          if_gnt, if_valid, if_err, ld_gnt, mem_we;
  logic [31:0]   if_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int tests = 0;
  int fails = 0;

  imem_arbiter #(.DEPTH(DEPTH), .AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Instruction memory driven purely by the DUT's port.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: shadow memory, pending-response queue keyed by due cycle,
  // and a count of consecutive loader wins while fetch waits.
  typedef struct { int due; bit err; logic [31:0] data; } resp_t;
  resp_t       pend[$];
  logic [31:0] shadow [DEPTH];
  int          starve = 0;
  int          cyc = 0;
  bit          prev_reset = 1'b1;

  typedef struct { bit err; logic [31:0] data; } seen_t;
  seen_t seen[$];
  int    dut_if_gnts = 0;
  int    dut_ld_gnts = 0;

  always @(negedge clk) begin
    bit m_force, m_ld, m_if;
    cyc++;
`ifdef IMEM_ARB_FAIR_EN
    m_force = (starve == SMAX) && if_req && !if_flush && !reset;
`else
    m_force = 1'b0;
`endif
    m_ld = !reset && ld_req && !m_force;
    m_if = !reset && !if_flush && if_req && (!ld_req || m_force);

    chk("ld_gnt", 32'(ld_gnt), 32'(m_ld));
    chk("if_gnt", 32'(if_gnt), 32'(m_if));
    if (m_ld) begin
      chk("mem_addr_ld", 32'(mem_addr), 32'(ld_addr % DEPTH));
      chk("mem_we_ld", 32'(mem_we), 32'(ld_addr < DEPTH));
      chk("mem_wdata_ld", mem_wdata, ld_wdata);
    end else if (m_if) begin
      chk("mem_addr_if", 32'(mem_addr), 32'(if_addr % DEPTH));
      chk("mem_we_if", 32'(mem_we), 32'd0);
    end else begin
      chk("mem_idle", {mem_wdata[23:0], mem_we, 7'(mem_addr)}, 32'd0);
    end

    if (pend.size() > 0 && pend[0].due == cyc) begin
      chk("if_valid", 32'(if_valid), 32'd1);
      chk("if_err", 32'(if_err), 32'(pend[0].err));
      chk("if_rdata", if_rdata, pend[0].data);
      void'(pend.pop_front());
    end else begin
      chk("if_valid_idle", 32'(if_valid), 32'd0);
      chk("if_err_idle", 32'(if_err), 32'd0);
    end
    if (prev_reset) chk("if_rdata_reset", if_rdata, 32'd0);

    if (if_valid) seen.push_back('{if_err, if_rdata});
    if (if_gnt) dut_if_gnts++;
    if (ld_gnt) dut_ld_gnts++;

    if (reset) begin
      pend.delete();
      starve = 0;
    end else begin
      if (if_flush) pend.delete();
      if (m_if) begin
        if (if_addr >= DEPTH) pend.push_back('{cyc + 2, 1'b1, 32'd0});
        else                  pend.push_back('{cyc + 2, 1'b0, shadow[if_addr]});
      end
      if (m_ld && ld_addr < DEPTH) shadow[ld_addr] = ld_wdata;
      if (!if_req || m_if) starve = 0;
      else if (m_ld && !if_flush && starve < SMAX) starve++;
    end
    prev_reset = reset;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, g0, l0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 32'h1000_0000 + 32'(i);
      shadow[i] = 32'h1000_0000 + 32'(i);
    end
    mem[0] = 32'h014A5020; shadow[0] = 32'h014A5020;
    mem[1] = 32'h00221822; shadow[1] = 32'h00221822;
    mem[2] = 32'h00632020; shadow[2] = 32'h00632020;

    reset = 1; if_req = 0; if_flush = 0; ld_req = 0;
    if_addr = 0; ld_addr = 0; ld_wdata = 0;
    step(3);
    reset = 0;
    step(1);

    // Fetch-only, three consecutive addresses.
    n0 = seen.size();
    if_req = 1;
    for (int a = 0; a < 3; a++) begin
      if_addr = 32'(a);
      step(1);
    end
    if_req = 0;
    step(4);
    chk("fetch_count", 32'(seen.size() - n0), 32'd3);
    if (seen.size() >= n0 + 3) begin
      chk("fetch_w0", seen[n0].data, 32'h014A5020);
      chk("fetch_w1", seen[n0 + 1].data, 32'h00221822);
      chk("fetch_w2", seen[n0 + 2].data, 32'h00632020);
    end

    // Write then read the same address on the next cycle.
    ld_req = 1; ld_addr = 5; ld_wdata = 32'hDEADBEEF;
    step(1);
    ld_req = 0; if_req = 1; if_addr = 5;
    step(1);
    if_req = 0;
    step(4);
    chk("wr_rd_data", seen[seen.size() - 1].data, 32'hDEADBEEF);

    // Out-of-range fetch and loader write.
    if_req = 1; if_addr = 128;
    step(1);
    if_req = 0;
    step(4);
    chk("oor_err", 32'(seen[seen.size() - 1].err), 32'd1);
    chk("oor_data", seen[seen.size() - 1].data, 32'd0);
    ld_req = 1; ld_addr = 200; ld_wdata = 32'h12345678;
    #1;
    chk("ld_oor_gnt", 32'(ld_gnt), 32'd1);
    chk("ld_oor_we", 32'(mem_we), 32'd0);
    step(1);
    ld_req = 0;
    step(2);

    // Contention: both requests held for 15 cycles.
    g0 = dut_if_gnts; l0 = dut_ld_gnts;
    ld_req = 1; ld_addr = 10; ld_wdata = 32'hA5A50001;
    if_req = 1; if_addr = 10;
    step(15);
    ld_req = 0; if_req = 0;
    step(4);
`ifdef IMEM_ARB_FAIR_EN
    chk("contend_if_gnts", 32'(dut_if_gnts - g0), 32'd3);
    chk("contend_ld_gnts", 32'(dut_ld_gnts - l0), 32'd12);
`else
    chk("contend_if_gnts", 32'(dut_if_gnts - g0), 32'd0);
    chk("contend_ld_gnts", 32'(dut_ld_gnts - l0), 32'd15);
`endif

    // Flush: grant in N, flush in N+1, new fetch in N+2 returns in N+4.
    n0 = seen.size();
    if_req = 1; if_addr = 1;
    step(1);
    if_flush = 1; if_addr = 2;
    step(1);
    if_flush = 0; if_addr = 2;
    step(1);
    if_req = 0;
    step(4);
    chk("flush_count", 32'(seen.size() - n0), 32'd1);
    if (seen.size() == n0 + 1) chk("flush_data", seen[n0].data, 32'h00632020);

    // Reset one cycle after a fetch grant.
    n0 = seen.size();
    if_req = 1; if_addr = 0;
    step(1);
    if_req = 0; reset = 1;
    step(1);
    reset = 0;
    step(4);
    chk("reset_drop", 32'(seen.size() - n0), 32'd0);

    // Reset together with flush and both requests.
    reset = 1; if_flush = 1; if_req = 1; ld_req = 1; if_addr = 3; ld_addr = 3;
    #1;
    chk("rst_flush_gnts", {30'd0, if_gnt, ld_gnt}, 32'd0);
    step(1);
    reset = 0; if_flush = 0; if_req = 0; ld_req = 0;
    step(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
